// File: rtl/barrel_divider_pkg.sv
// Shared constants for the barrel divider: default widths and the barrel stage count.
// Stage count is clog2 of the data width: one stage per shift_n bit that can move data.
package barrel_divider_pkg;

    localparam int DEFAULT_WIDTH   = 8;
    localparam int DEFAULT_SHIFT_W = 4;
    localparam int STAGE_COUNT     = $clog2(DEFAULT_WIDTH);

    // Stages needed for an arbitrary width; used when WIDTH is overridden.
    function automatic int stage_count(input int width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/barrel_divider_stage.sv
// One barrel stage: arithmetic right shift by a fixed amount S when enabled,
// otherwise pass the data through unchanged.
module barrel_shift_stage #(
    parameter int WIDTH = 8,
    parameter int S     = 1
) (
    input  logic [WIDTH-1:0] data_i,
    input  logic             en,
    output logic [WIDTH-1:0] data_o
);

    logic [WIDTH-1:0] shifted;

    assign shifted = WIDTH'($signed(data_i) >>> S);
    assign data_o  = en ? shifted : data_i;

endmodule

// File: rtl/barrel_divider.sv
// Signed divide by 2^n (floor): log2 barrel of arithmetic shift stages,
// a saturation mux for n >= WIDTH, and a single output register.
module barrel_divider
    import barrel_divider_pkg::*;
#(
    parameter int WIDTH   = DEFAULT_WIDTH,
    parameter int SHIFT_W = DEFAULT_SHIFT_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [WIDTH-1:0]   x,
    input  logic [SHIFT_W-1:0] shift_n,
    output logic [WIDTH-1:0]   y
);

    localparam int STAGES = stage_count(WIDTH);
    localparam logic [SHIFT_W-1:0] WIDTH_N = SHIFT_W'(WIDTH);

    logic [WIDTH-1:0] stage_data [0:STAGES];
    logic             saturate;
    logic [WIDTH-1:0] y_d;
    logic [WIDTH-1:0] y_q;

    assign stage_data[0] = x;

    generate
        for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
            barrel_shift_stage #(
                .WIDTH (WIDTH),
                .S     (1 << gi)
            ) u_stage (
                .data_i (stage_data[gi]),
                .en     (shift_n[gi]),
                .data_o (stage_data[gi+1])
            );
        end
    endgenerate

    // Any count at or beyond the width leaves only sign bits, including
    // counts carried solely in shift_n bits above the barrel stages.
    assign saturate = (shift_n >= WIDTH_N);

    always_comb begin
        y_d = stage_data[STAGES];
        if (saturate) begin
            y_d = {WIDTH{x[WIDTH-1]}};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_q <= '0;
        end else begin
            y_q <= y_d;
        end
    end

    assign y = y_q;

endmodule

// File: tb/tb_barrel_divider.sv
// Bench for barrel_divider: directed literal vectors plus a floor-division
// model checked against y on every cycle.
module tb_barrel_divider;

    logic       clk;
    logic       rst_n;
    logic [7:0] x;
    logic [3:0] shift_n;
    logic [7:0] y;

    int total = 0;
    int bad   = 0;

    logic       cmp_en = 1'b0;
    logic [7:0] exp_q;

    barrel_divider #(
        .WIDTH   (8),
        .SHIFT_W (4)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .x       (x),
        .shift_n (shift_n),
        .y       (y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // floor(x / 2^n) with plain integer arithmetic.
    function automatic logic [7:0] model(input logic [7:0] xv, input logic [3:0] nv);
        int xi;
        int d;
        int q;
        xi = int'($signed(xv));
        if (nv >= 4'd8) begin
            return (xi < 0) ? 8'hFF : 8'h00;
        end
        d = 1 << nv;
        q = xi / d;
        if ((xi % d != 0) && (xi < 0)) q = q - 1;
        return q[7:0];
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: y=%h expected=%h (x=%h n=%0d)", name, act, req, x, shift_n);
        end else begin
            $display("ok   %s: y=%h (x=%h n=%0d)", name, act, x, shift_n);
        end
    endtask

    // Expected output: inputs sampled at each rising edge, cleared by reset.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) exp_q <= 8'h00;
        else        exp_q <= model(x, shift_n);
    end

    always @(negedge clk) begin
        if (cmp_en) check("model", y, exp_q);
    end

    task automatic apply(input logic [7:0] xv, input logic [3:0] nv,
                         input logic [7:0] req, input string name);
        @(negedge clk);
        x       = xv;
        shift_n = nv;
        @(posedge clk);
        #1;
        check(name, y, req);
    endtask

    logic [7:0] neg_tab [0:7];
    logic [7:0] pos_tab [0:7];
    logic [7:0] hold_val;

    initial begin
        neg_tab = '{8'hE9, 8'hF4, 8'hFA, 8'hFD, 8'hFE, 8'hFF, 8'hFF, 8'hFF};
        pos_tab = '{8'h17, 8'h0B, 8'h05, 8'h02, 8'h01, 8'h00, 8'h00, 8'h00};

        rst_n   = 1'b0;
        x       = 8'hE9;
        shift_n = 4'd1;
        @(posedge clk);
        #1;
        check("reset_low", y, 8'h00);
        @(negedge clk);
        rst_n  = 1'b1;
        cmp_en = 1'b1;
        @(posedge clk);
        #1;
        check("first_after_reset", y, 8'hF4);

        for (int i = 0; i < 8; i++) apply(8'hE9, 4'(i), neg_tab[i], $sformatf("neg23_n%0d", i));
        for (int i = 0; i < 8; i++) apply(8'h17, 4'(i), pos_tab[i], $sformatf("pos23_n%0d", i));

        apply(8'hE9, 4'd8,  8'hFF, "sat_neg_n8");
        apply(8'hE9, 4'd15, 8'hFF, "sat_neg_n15");
        apply(8'h17, 4'd8,  8'h00, "sat_pos_n8");
        apply(8'h17, 4'd15, 8'h00, "sat_pos_n15");
        apply(8'h80, 4'd7,  8'hFF, "minval_n7");
        apply(8'h80, 4'd0,  8'h80, "minval_n0");
        apply(8'h7F, 4'd6,  8'h01, "maxval_n6");

        // Inputs changing mid-cycle must not reach y before the next edge.
        apply(8'h64, 4'd2, 8'h19, "hold_setup");
        hold_val = y;
        @(negedge clk);
        x       = 8'h9C;
        shift_n = 4'd1;
        #2;
        check("hold_midcycle", y, 8'h19);
        @(posedge clk);
        #1;
        check("hold_next_edge", y, 8'hCE);

        // Asynchronous reset between edges with y nonzero.
        #1;
        rst_n = 1'b0;
        #1;
        check("async_reset", y, 8'h00);
        @(posedge clk);
        #1;
        check("reset_ignores_clk", y, 8'h00);
        x       = 8'hE9;
        shift_n = 4'd3;
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("release_load", y, 8'hFD);

        // Random stream checked by the model process every cycle.
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            x       = 8'($urandom_range(0, 255));
            shift_n = 4'($urandom_range(0, 15));
        end
        @(negedge clk);
        @(negedge clk);
        cmp_en = 1'b0;
        if (hold_val === 8'hxx) $display("note: hold value unknown");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
